// File: rtl/pipe_arbiter_pkg.sv
// Shared constants and helpers for the pipe_arbiter slice.
//   ARB_OPEN / ARB_LOCK : arbiter FSM state encodings
//   idx_width()         : requester index width, never narrower than 1 bit
//   next_idx()          : round-robin successor of an index, modulo n
package pipe_arbiter_pkg;

    localparam logic [0:0] ARB_OPEN = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/pipe_arbiter_if.sv
// Bundle of the arbiter's upstream (per-requester) and downstream stream signals.
//   data_in/last_in/valid_in : per-requester beat, driven by requesters
//   ready_in                 : per-requester accept, driven by the arbiter
//   data_out/last_out/src_out/valid_out : registered merged stream
//   ready_out                : downstream accept
// master = requesters + downstream sink, slave = arbiter.
interface pipe_arbiter_if #(
    parameter type         T     = logic [31:0],
    parameter int unsigned N_REQ = 4
);
    import pipe_arbiter_pkg::*;

    localparam int unsigned IDX_W = idx_width(N_REQ);

    T                 data_in [N_REQ];
    logic [N_REQ-1:0] last_in;
    logic [N_REQ-1:0] valid_in;
    logic [N_REQ-1:0] ready_in;
    T                 data_out;
    logic             last_out;
    logic [IDX_W-1:0] src_out;
    logic             valid_out;
    logic             ready_out;

    modport master (
        output data_in, last_in, valid_in, ready_out,
        input  ready_in, data_out, last_out, src_out, valid_out
    );

    modport slave (
        input  data_in, last_in, valid_in, ready_out,
        output ready_in, data_out, last_out, src_out, valid_out
    );

endinterface

// File: rtl/pipe_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward, wrapping.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   found : any request set
//   idx   : chosen index (0 when found=0)
module rr_pick
    import pipe_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = (32'(ptr) + i) % N_REQ;
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready requesters into one registered stream.
// Multi-beat packets keep the grant until the beat carrying last; each beat is tagged
// with its source index.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   flush_i : drop the held output beat and release any packet lock
//   bus     : pipe_arbiter_if slave (upstream requesters + downstream sink)
module pipe_arbiter
    import pipe_arbiter_pkg::*;
#(
    parameter type         T     = logic [31:0],
    parameter int unsigned N_REQ = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    pipe_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    logic [0:0]       state_q,  state_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    T                 data_q,   data_d;
    logic             last_q,   last_d;
    logic [IDX_W-1:0] src_q,    src_d;
    logic             valid_q,  valid_d;

    logic             load_en;
    logic             accept;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] ready_c;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (bus.valid_in),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant selection, ready generation and next-state for FSM and output register.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        data_d    = data_q;
        last_d    = last_q;
        src_d     = src_q;
        valid_d   = valid_q;
        ready_c   = '0;
        accept    = 1'b0;
        grant_idx = pick_idx;

        // Reset gating keeps ready_in low during the reset cycle.
        load_en = !rst_i && !flush_i && (!valid_q || bus.ready_out);

        case (state_q)
            ARB_LOCK: begin
                // Owner sees ready whether or not it is valid; nobody else is eligible.
                grant_idx          = owner_q;
                ready_c[owner_q]   = load_en;
                accept             = load_en && bus.valid_in[owner_q];
            end
            default: begin
                grant_idx          = pick_idx;
                ready_c[pick_idx]  = load_en && pick_found;
                accept             = load_en && pick_found;
            end
        endcase

        if (accept) begin
            data_d  = bus.data_in[grant_idx];
            last_d  = bus.last_in[grant_idx];
            src_d   = grant_idx;
            valid_d = 1'b1;
            if (state_q == ARB_OPEN) begin
                rr_ptr_d = IDX_W'(next_idx(32'(grant_idx), N_REQ));
                if (!bus.last_in[grant_idx]) begin
                    state_d = ARB_LOCK;
                    owner_d = grant_idx;
                end
            end else if (bus.last_in[grant_idx]) begin
                state_d = ARB_OPEN;
            end
        end else if (load_en) begin
            valid_d = 1'b0;
        end

        // Flush empties the output stage and reopens arbitration; rr_ptr is kept.
        if (flush_i) begin
            valid_d = 1'b0;
            state_d = ARB_OPEN;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_OPEN;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            src_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            src_q    <= src_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.ready_in  = ready_c;
    assign bus.data_out  = data_q;
    assign bus.last_out  = last_q;
    assign bus.src_out   = src_q;
    assign bus.valid_out = valid_q;

endmodule
